// File: rtl/hvac_pkg.sv
// Shared encodings and default timing for the HVAC zone scheduler.
package hvac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2
  } state_e;

  typedef enum logic {
    MODE_HEAT = 1'b0,
    MODE_COOL = 1'b1
  } mode_e;

  localparam int DEF_N_ZONES   = 4;
  localparam int DEF_MIN_RUN   = 8;
  localparam int DEF_SLOT_MAX  = 16;
  localparam int DEF_DEAD_TIME = 4;

endpackage : hvac_pkg

// File: rtl/hvac_zone_scheduler_if.sv
// Zone-request / plant-command bundle between the zone monitors, the
// scheduler and the plant output drivers.
interface hvac_zone_scheduler_if #(
  parameter int N_ZONES = 4
) ();

  logic               enable;
  logic [N_ZONES-1:0] heat_req;
  logic [N_ZONES-1:0] cool_req;
  logic               plant_heat;
  logic               plant_cool;
  logic [N_ZONES-1:0] zone_valve;
  logic [2:0]         active_zone;
  logic               busy;

  // Requester side: zone monitors drive requests, observe plant commands.
  modport master (
    output enable, heat_req, cool_req,
    input  plant_heat, plant_cool, zone_valve, active_zone, busy
  );

  // Scheduler side.
  modport slave (
    input  enable, heat_req, cool_req,
    output plant_heat, plant_cool, zone_valve, active_zone, busy
  );

endinterface : hvac_zone_scheduler_if

// File: rtl/hvac_rr_arbiter.sv
// Combinational round-robin pick: first requesting zone strictly after
// the pointer, wrapping, so the most recently served zone comes last.
module hvac_rr_arbiter #(
  parameter int N_ZONES = 4
) (
  input  logic [N_ZONES-1:0] req,
  input  logic [2:0]         ptr,
  output logic               grant_valid,
  output logic [2:0]         grant_idx
);

  logic [7:0] req_ext;
  logic [3:0] cand;

  assign req_ext = 8'(req);

  // Scan zones ptr+1 .. ptr+N_ZONES (mod N_ZONES); the first hit wins.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    grant_valid = 1'b0;
    grant_idx   = ptr;
    cand        = '0;
    for (int k = 1; k <= N_ZONES; k++) begin
      cand = {1'b0, ptr} + 4'(k);
      if (cand >= 4'(N_ZONES)) cand = cand - 4'(N_ZONES);
      if (!grant_valid && req_ext[cand[2:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = cand[2:0];
      end
    end
  end

endmodule : hvac_rr_arbiter

// File: rtl/hvac_zone_scheduler.sv
// Shares one heat-pump plant between zones: round-robin grant, compressor
// minimum run time, fairness slot limit and dead time between grants.
module hvac_zone_scheduler
  import hvac_pkg::*;
#(
  parameter int N_ZONES   = DEF_N_ZONES,
  parameter int MIN_RUN   = DEF_MIN_RUN,
  parameter int SLOT_MAX  = DEF_SLOT_MAX,
  parameter int DEAD_TIME = DEF_DEAD_TIME
) (
  input logic                 clk,
  input logic                 rst_n,
  hvac_zone_scheduler_if.slave bus
);

  localparam int RUN_W  = $clog2(SLOT_MAX + 1);
  localparam int DEAD_W = $clog2(DEAD_TIME + 1);

  localparam logic [RUN_W-1:0]  RUN_MIN_LAST  = RUN_W'(MIN_RUN - 1);
  localparam logic [RUN_W-1:0]  RUN_SLOT_LAST = RUN_W'(SLOT_MAX - 1);
  localparam logic [RUN_W-1:0]  RUN_SAT       = RUN_W'(SLOT_MAX);
  localparam logic [DEAD_W-1:0] DEAD_LAST     = DEAD_W'(DEAD_TIME - 1);

  if (N_ZONES < 2 || N_ZONES > 8) begin : g_bad_zones
    $error("hvac_zone_scheduler: N_ZONES must be 2..8");
  end
  if (MIN_RUN < 1 || MIN_RUN > SLOT_MAX) begin : g_bad_min_run
    $error("hvac_zone_scheduler: MIN_RUN must be 1..SLOT_MAX");
  end
  if (DEAD_TIME < 1) begin : g_bad_dead
    $error("hvac_zone_scheduler: DEAD_TIME must be >= 1");
  end

  state_e             state_q, state_d;
  mode_e              mode_q, mode_d;
  logic [RUN_W-1:0]   run_cnt_q, run_cnt_d;
  logic [DEAD_W-1:0]  dead_cnt_q, dead_cnt_d;
  logic [2:0]         zone_q, zone_d;
  logic [2:0]         ptr_q, ptr_d;

  logic [N_ZONES-1:0] req;
  logic [7:0]         req_ext, heat_ext, cool_ext;
  logic [7:0]         zone_mask, valve_ext;
  logic               grant_valid;
  logic [2:0]         grant_idx;
  logic               zone_heat, zone_cool, mode_ok;
  logic               others_req, min_done, slot_done;

  // Disabled plant looks like every zone dropped its request.
  assign req      = bus.enable ? (bus.heat_req | bus.cool_req) : '0;
  assign req_ext  = 8'(req);
  assign heat_ext = 8'(bus.heat_req);
  assign cool_ext = 8'(bus.cool_req);

  hvac_rr_arbiter #(.N_ZONES(N_ZONES)) u_arb (
    .req         (req),
    .ptr         (ptr_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Does the granted zone still want the mode it was granted in? Heat
  // wins when both are asserted, so a cool grant is lost as soon as heat
  // shows up for the same zone.
  assign zone_heat  = bus.enable & heat_ext[zone_q];
  assign zone_cool  = bus.enable & cool_ext[zone_q] & ~heat_ext[zone_q];
  assign mode_ok    = (mode_q == MODE_HEAT) ? zone_heat : zone_cool;
  assign zone_mask  = 8'b1 << zone_q;
  assign others_req = |(req_ext & ~zone_mask);
  assign min_done   = run_cnt_q >= RUN_MIN_LAST;
  assign slot_done  = run_cnt_q >= RUN_SLOT_LAST;

  // Next-state: grant from IDLE, hold/exit in RUN, time out DEAD.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    run_cnt_d  = run_cnt_q;
    dead_cnt_d = dead_cnt_q;
    zone_d     = zone_q;
    ptr_d      = ptr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          state_d   = ST_RUN;
          zone_d    = grant_idx;
          ptr_d     = grant_idx;
          run_cnt_d = '0;
          mode_d    = heat_ext[grant_idx] ? MODE_HEAT : MODE_COOL;
        end
      end
      ST_RUN: begin
        // Compressor protection: no exit before the minimum run time.
        if (min_done && (!mode_ok || (slot_done && others_req))) begin
          state_d    = ST_DEAD;
          dead_cnt_d = '0;
        end else if (run_cnt_q != RUN_SAT) begin
          run_cnt_d = run_cnt_q + 1'b1;
        end
      end
      ST_DEAD: begin
        if (dead_cnt_q == DEAD_LAST) state_d = ST_IDLE;
        else                         dead_cnt_d = dead_cnt_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign valve_ext = 8'b1 << zone_d;

  // State, counters and outputs, all registered from next-state values.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      mode_q         <= MODE_HEAT;
      run_cnt_q      <= '0;
      dead_cnt_q     <= '0;
      zone_q         <= '0;
      ptr_q          <= 3'(N_ZONES - 1);
      bus.plant_heat <= 1'b0;
      bus.plant_cool <= 1'b0;
      bus.zone_valve <= '0;
      bus.busy       <= 1'b0;
    end else begin
      state_q        <= state_d;
      mode_q         <= mode_d;
      run_cnt_q      <= run_cnt_d;
      dead_cnt_q     <= dead_cnt_d;
      zone_q         <= zone_d;
      ptr_q          <= ptr_d;
      bus.plant_heat <= (state_d == ST_RUN) && (mode_d == MODE_HEAT);
      bus.plant_cool <= (state_d == ST_RUN) && (mode_d == MODE_COOL);
      bus.zone_valve <= (state_d == ST_RUN) ? valve_ext[N_ZONES-1:0] : '0;
      bus.busy       <= (state_d != ST_IDLE);
    end
  end

  assign bus.active_zone = zone_q;

  a_heat_cool_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.plant_heat && bus.plant_cool));
  a_valve_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(bus.zone_valve));

endmodule : hvac_zone_scheduler

// File: tb/tb_hvac_zone_scheduler.sv
// Scoreboard bench for hvac_zone_scheduler: a cycle-level reference model
// pushes the expected plant outputs after every clock edge, a monitor pops
// and compares them on the falling edge.
module tb_hvac_zone_scheduler;

  localparam int N         = 4;
  localparam int MIN_RUN   = 8;
  localparam int SLOT_MAX  = 16;
  localparam int DEAD_TIME = 4;

  logic clk;
  logic rst_n;

  hvac_zone_scheduler_if #(.N_ZONES(N)) bus ();

  hvac_zone_scheduler #(
    .N_ZONES   (N),
    .MIN_RUN   (MIN_RUN),
    .SLOT_MAX  (SLOT_MAX),
    .DEAD_TIME (DEAD_TIME)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Packed view: {busy, plant_heat, plant_cool, active_zone[2:0], valve[3:0]}
  logic [9:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] dut_view();
    return {bus.busy, bus.plant_heat, bus.plant_cool, bus.active_zone, bus.zone_valve};
  endfunction

  // ---------------- reference model ----------------
  // owner  : zone holding the plant, -1 when none
  // ran    : completed grant cycles before the current one
  // gap    : blackout cycles still to serve after a grant ends
  // last   : most recently granted zone (reported as active_zone)
  // served : round-robin reference, starts so zone 0 is served first
  int m_owner, m_ran, m_gap, m_last, m_served;
  bit m_heat;

  function automatic bit m_req(int z);
    return bus.enable && (bus.heat_req[z] || bus.cool_req[z]);
  endfunction

  always @(posedge clk) begin
    logic [9:0] e;
    if (!rst_n) begin
      m_owner = -1; m_ran = 0; m_gap = 0; m_last = 0; m_served = N - 1; m_heat = 1'b1;
    end else if (m_owner >= 0) begin
      bit still_wants, rival;
      still_wants = m_heat ? (bus.enable && bus.heat_req[m_owner])
                           : (bus.enable && bus.cool_req[m_owner] && !bus.heat_req[m_owner]);
      rival = 1'b0;
      for (int z = 0; z < N; z++) if (z != m_owner && m_req(z)) rival = 1'b1;
      if (m_ran >= MIN_RUN - 1 && (!still_wants || (m_ran >= SLOT_MAX - 1 && rival))) begin
        m_owner = -1;
        m_gap   = DEAD_TIME;
      end else begin
        m_ran++;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else begin
      for (int k = 1; k <= N; k++) begin
        int z;
        z = (m_served + k) % N;
        if (m_owner < 0 && m_req(z)) begin
          m_owner  = z;
          m_served = z;
          m_last   = z;
          m_ran    = 0;
          m_heat   = bus.heat_req[z];
        end
      end
    end
    e = '0;
    e[6:4] = 3'(m_last);
    if (m_owner >= 0) begin
      e[9]   = 1'b1;
      e[8]   = m_heat;
      e[7]   = !m_heat;
      e[3:0] = 4'(1 << m_owner);
    end else if (m_gap > 0) begin
      e[9] = 1'b1;
    end
    exp_q.push_back(e);
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    cyc++;
    if (exp_q.size() > 0) begin
      logic [9:0] e;
      e = exp_q.pop_front();
      check($sformatf("outputs@cycle%0d", cyc), 32'(dut_view()), 32'(e));
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [3:0] h, input logic [3:0] c, input logic en, input int cycles);
    bus.heat_req = h;
    bus.cool_req = c;
    bus.enable   = en;
    repeat (cycles) @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.enable   = 1'b1;
    bus.heat_req = '0;
    bus.cool_req = '0;
    #1;
    check("reset_outputs", 32'(dut_view()), 32'd0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    // 1: short heat request still runs the full minimum, then dead time.
    drive(4'b0001, 4'b0000, 1'b1, 2);
    drive(4'b0000, 4'b0000, 1'b1, 20);
    // 2: two zones held -> slot rotation with dead time between grants.
    drive(4'b0001, 4'b0100, 1'b1, 60);
    drive(4'b0000, 4'b0000, 1'b1, 20);
    // 3: single cooler held past the slot limit keeps running.
    drive(4'b0000, 4'b1000, 1'b1, 40);
    drive(4'b0000, 4'b0000, 1'b1, 20);
    // 4: heat -> cool swap on the same zone.
    drive(4'b0010, 4'b0000, 1'b1, 10);
    drive(4'b0000, 4'b0010, 1'b1, 20);
    drive(4'b0000, 4'b0000, 1'b1, 20);
    // 5: both modes set (heat wins), enable dropped early.
    drive(4'b0010, 4'b0010, 1'b1, 3);
    drive(4'b0010, 4'b0010, 1'b0, 20);
    drive(4'b0000, 4'b0000, 1'b1, 5);
    // 6: reset mid-run drops outputs at once; grant resumes on release.
    drive(4'b0010, 4'b0000, 1'b1, 5);
    rst_n = 1'b0;
    #1;
    check("async_reset_drop", 32'(dut_view()), 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    drive(4'b0010, 4'b0000, 1'b1, 10);
    drive(4'b0000, 4'b0000, 1'b1, 20);

    // Random traffic: sparse request patterns held for random spans.
    repeat (40) begin
      logic [3:0] h, c;
      h = 4'($urandom) & 4'($urandom);
      c = 4'($urandom) & 4'($urandom);
      drive(h, c, ($urandom_range(0, 7) != 0), $urandom_range(1, 24));
    end
    drive(4'b0000, 4'b0000, 1'b1, 30);

    repeat (2) @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_hvac_zone_scheduler
